// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and helpers for the 4-digit display scan controller.
//   scan_state_t : per-slot FSM state (dead time, then drive)
//   N_DIGITS     : number of multiplexed digits
//   AN_OFF       : all anodes disabled (active-low)
//   digit_nibble : selects hex digit k of a 16-bit display word
//   digit_blank  : leading-zero test for digit k (digit 0 never blanks)
//   anode_on     : active-low one-hot anode pattern for digit k
package display_pkg;

    typedef enum logic [0:0] {S_DEAD, S_DRIVE} scan_state_t;

    localparam int N_DIGITS = 4;
    localparam logic [3:0] AN_OFF = 4'b1111;

    function automatic logic [3:0] digit_nibble(logic [15:0] v, logic [1:0] k);
        return v[4*k +: 4];
    endfunction

    // Digit k is a leading zero when it and every digit above it are zero.
    function automatic logic digit_blank(logic [15:0] v, logic [1:0] k);
        logic res;
        case (k)
            2'd1:    res = (v[15:4] == 12'h000);
            2'd2:    res = (v[15:8] == 8'h00);
            2'd3:    res = (v[15:12] == 4'h0);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] anode_on(logic [1:0] k);
        return ~(4'b0001 << k);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bus between the datapath / board pins and the display scan controller.
//   value       : 16-bit word to display, sampled on load
//   load        : one-cycle strobe capturing value
//   blank_lz    : leading-zero suppression enable (level)
//   an          : active-low anode enables
//   s_muxfue    : nibble for the display7 decoder
//   frame_start : one-cycle pulse at the start of digit 0's slot
// master: the side that supplies values; slave: the scan controller.
interface display_scan_ctrl_if;

    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  an;
    logic [3:0]  s_muxfue;
    logic        frame_start;

    modport master (
        output value,
        output load,
        output blank_lz,
        input  an,
        input  s_muxfue,
        input  frame_start
    );

    modport slave (
        input  value,
        input  load,
        input  blank_lz,
        output an,
        output s_muxfue,
        output frame_start
    );

endinterface

// File: rtl/display_scan_ctrl_scan_tick.sv
// Slot timing counter for the display scan controller.
//   clk, rst : clock and synchronous active-high reset
//   dead_end : last cycle of the dead time of the current slot
//   slot_end : last cycle of the current slot (next edge starts a slot)
//   first    : high while idle after reset; the next edge starts digit 0
// After reset the counter idles with slot_end high so that the first
// edge after release begins a fresh slot at count 0.
module scan_tick #(
    parameter int unsigned TICK_DIV = 27000,
    parameter int unsigned DEAD     = 4,
    localparam int unsigned CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic clk,
    input  logic rst,
    output logic dead_end,
    output logic slot_end,
    output logic first
);

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;

    assign first    = !run_q;
    assign slot_end = !run_q || (cnt_q == CNT_W'(TICK_DIV - 1));
    assign dead_end = run_q && (cnt_q == CNT_W'(DEAD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= 1'b1;
            if (slot_end) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode display.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of display_scan_ctrl_if (value/load/blank_lz in,
//              an/s_muxfue/frame_start out, all outputs registered)
// Each slot starts with DEAD all-off cycles, then drives one anode for the
// rest of the slot. New values are staged in pend and only move to disp
// at the digit 3 -> 0 transition, so a frame never mixes two values.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned TICK_DIV = 27000,
    parameter int unsigned DEAD     = 4
) (
    input  logic                clk,
    input  logic                rst,
    display_scan_ctrl_if.slave  bus
);

    logic dead_end;
    logic slot_end;
    logic first;

    scan_tick #(
        .TICK_DIV (TICK_DIV),
        .DEAD     (DEAD)
    ) u_scan_tick (
        .clk      (clk),
        .rst      (rst),
        .dead_end (dead_end),
        .slot_end (slot_end),
        .first    (first)
    );

    scan_state_t state;
    logic [15:0] pend;
    logic [15:0] disp;
    logic [1:0]  idx;
    logic        blank_slot;
    logic [3:0]  an_r;
    logic [3:0]  mux_r;
    logic        fs_r;

    logic [1:0]  idx_next;
    logic        frame_bound;
    logic [15:0] disp_src;

    // The first slot after reset is digit 0 and counts as a frame boundary.
    assign idx_next    = first ? 2'd0 : idx + 2'd1;
    assign frame_bound = slot_end && (first || (idx == 2'd3));
    // At a boundary the new slot must already see the word being latched.
    assign disp_src    = frame_bound ? pend : disp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_DEAD;
            pend       <= 16'h0000;
            disp       <= 16'h0000;
            idx        <= 2'd0;
            blank_slot <= 1'b0;
            an_r       <= AN_OFF;
            mux_r      <= 4'h0;
            fs_r       <= 1'b0;
        end else begin
            fs_r <= 1'b0;
            // pend is read (old value) before this write takes effect, so a
            // load in the boundary cycle lands in the following frame.
            if (bus.load) begin
                pend <= bus.value;
            end

            case (state)
                S_DEAD: begin
                    if (dead_end) begin
                        state <= S_DRIVE;
                        an_r  <= blank_slot ? AN_OFF : anode_on(idx);
                    end
                end
                S_DRIVE: begin
                    an_r <= an_r;
                end
                default: begin
                    state <= S_DEAD;
                end
            endcase

            if (slot_end) begin
                state      <= S_DEAD;
                an_r       <= AN_OFF;
                idx        <= idx_next;
                mux_r      <= digit_nibble(disp_src, idx_next);
                blank_slot <= bus.blank_lz && digit_blank(disp_src, idx_next);
                fs_r       <= frame_bound;
                if (frame_bound) begin
                    disp <= pend;
                end
            end
        end
    end

    assign bus.an          = an_r;
    assign bus.s_muxfue    = mux_r;
    assign bus.frame_start = fs_r;

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode 7-segment display. It holds a 16-bit display value and rotates through the digits. For each digit it drives one anode low and presents that digit's nibble on `s_muxfue` to the existing `display7` decoder. It sits between the datapath result register and `display7`/board pins, and adds anti-ghosting dead time, tear-free frame updates and optional leading-zero blanking.

## Interface
- `TICK_DIV`, default 27000: clock cycles per digit slot (1 kHz slot rate at 27 MHz). Legal range: TICK_DIV ≥ DEAD+2.
- `DEAD`, default 4: cycles at the start of each slot with all anodes off. Legal range: DEAD ≥ 1.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `value`  in  16  four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `load`  in  1  one-cycle strobe that samples `value`.
- `blank_lz`  in  1  enables leading-zero suppression; level-sensitive, sampled at slot start.
- `an`  out  4  anode enables, active-low; one-hot-low or all-high.
- `s_muxfue`  out  4  nibble for the `display7` decoder.
- `frame_start`  out  1  one-cycle pulse on the first cycle of digit-0's slot.

## Operation
- **Registers:**
  - `pend[15:0]`: written with `value` on every cycle where `load`=1; the last load wins.
  - `disp[15:0]`: copied from `pend` only at a frame boundary.
  - `idx[1:0]`: digit index.
  - `cnt`: slot cycle counter, width $clog2(TICK_DIV).
- **FSM states:** `S_DEAD`, `S_DRIVE`.
  - `S_DEAD`: `an`=4'b1111. When `cnt`==DEAD-1, go to `S_DRIVE`.
  - `S_DRIVE`: `an` has bit `idx` low, unless the digit is blanked (then all high). When `cnt`==TICK_DIV-1: `cnt`←0, `idx`←`idx`+1 (wrapping 3→0), go to `S_DEAD`.
- **Frame boundary** (the slot transition with `idx` 3→0):
  - `disp`←`pend`.
  - `frame_start`=1 on the first `S_DEAD` cycle of digit 0.
  - If `load` is asserted in that same boundary cycle, `disp` takes the old `pend`. The new value is displayed from the following frame.
- **Slot start:** `s_muxfue`←`disp[4*idx_next +: 4]`. It is held constant for the entire slot, so it is stable through the dead time.
- **Leading-zero blanking** (when `blank_lz`=1):
  - Digit k (k=1..3) is blanked iff `disp` nibbles k..3 are all zero.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - A blanked digit still consumes its slot (constant brightness); its anode stays high.
- **Reset:**
  - `an`=4'b1111, `s_muxfue`=4'h0, `frame_start`=0.
  - `idx`=0, `cnt`=0, `pend`=`disp`=16'h0, state `S_DEAD`.
  - The first cycle after reset release is treated as a frame start (`frame_start`=1).
  - Reset asserted mid-slot forces all of the above on the next edge; no partial digit is driven.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Slot = TICK_DIV cycles: DEAD cycles in `S_DEAD`, then TICK_DIV−DEAD cycles in `S_DRIVE`.
- Frame = 4·TICK_DIV cycles.
- `frame_start` period = 4·TICK_DIV.
- **Load-to-display latency:** from the `load` cycle to the next frame boundary (maximum 4·TICK_DIV cycles), plus DEAD cycles until the digit-0 anode is low.
- Exactly 0 or 1 bits of `an` are low in every cycle; never two.
- An `an` transition from one digit to another always passes through ≥ DEAD all-high cycles.

## Structure
- Package `display_pkg`:
  - `typedef enum logic [0:0] {S_DEAD, S_DRIVE} scan_state_t`.
  - `localparam int N_DIGITS = 4`.
  - Constant `AN_OFF = 4'b1111`.
- Natural sub-module: `scan_tick`, a parameterised slot counter that emits `dead_end` and `slot_end` strobes.
- `display7` is instantiated one level up, at board top, fed by `s_muxfue`.

## Test plan
All scenarios use TICK_DIV=8, DEAD=2.
1. **Reset:** hold `rst` for 3 cycles, then release → `an`=1111 and `s_muxfue`=0 during reset; `frame_start` on the first cycle after release; `an` goes to 1110 at cycle 2 after release with `s_muxfue`=0.
2. **Scan order:** `load` 16'h1234, run 2 frames → second-frame slots show `s_muxfue` 4,3,2,1 with `an` 1110,1101,1011,0111; exactly 6 low cycles per slot; 2 all-high cycles between slots.
3. **Tear-free update:** `load` 16'hABCD mid digit-1 slot → digits 2 and 3 of the current frame still show the old value; the next frame shows D,C,B,A.
4. **Boundary collision:** `load` 16'h5555 in the frame-boundary cycle, with prior `pend`=16'h1111 → the next frame shows 1111; the frame after shows 5555.
5. **Leading-zero blanking:** `blank_lz`=1 with values 16'h0007, 16'h0000 and 16'h0100 →
   - 0007: only digit 0 lit.
   - 0000: only digit 0 lit, showing 0.
   - 0100: digits 0–2 lit, digit 3 dark, still 8 cycles per slot.
6. **Mid-slot reset:** assert `rst` during digit-2 `S_DRIVE` → next cycle `an`=1111 and `s_muxfue`=0; `pend` cleared; scan restarts at digit 0.
